delay_controller: RTL and testbench
===================================

DELAY_CONTROLLER -- requirements
Module: delay_controller

Interface
REQ-001 The block SHALL have one clock (clk) and a synchronous, active-high reset (rst).
REQ-002 The block SHALL expose parameter NUM_RUNS, default 8: the number of measurements per start, legal range 1..255.
REQ-003 The block SHALL expose parameter TIMEOUT_CYC, default 1024: the maximum number of WAIT cycles per run, legal range 1..65535.
REQ-004 The ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to begin a measurement batch
- result  in  32  free-running count from the delay datapath; it increments by 1 per clk while ld=1
- pathResult  in  1  asynchronous output of the delay path under test
- ld  out  1  count enable to the datapath register
- pathInput  out  1  launch edge driven into the delay path
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a batch
- timeout  out  1  sticky abort flag, cleared by the next accepted start
- last_delay  out  32  delta of the most recent run
- delay_sum  out  40  accumulated deltas for the batch
- run_count  out  8  number of completed runs in the batch

Function
REQ-005 pathResult SHALL pass through a 2-flop synchronizer (sync1 -> sync2) before any use; no other logic SHALL sample it.
REQ-006 The FSM states SHALL be IDLE, ARM, LAUNCH, WAIT, RECORD and DONE; every state and output SHALL be registered.
REQ-007 IDLE: ld=0; a start in IDLE SHALL clear delay_sum, run_count and timeout, then go to ARM; a start in any other state SHALL be ignored.
REQ-008 ARM: ld=1 and settle for exactly 4 cycles; on the last ARM cycle, ref_level SHALL be latched from sync2, then go to LAUNCH.
REQ-009 LAUNCH: on the LAUNCH->WAIT edge, pathInput SHALL toggle, start_cnt SHALL latch result, and the wait counter SHALL clear; this state lasts 1 cycle.
REQ-010 WAIT: the wait counter SHALL increment each cycle. When sync2 != ref_level, end_cnt SHALL latch result and the FSM SHALL go to RECORD; detection SHALL be polarity-agnostic.
REQ-011 WAIT timeout: when the wait counter reaches TIMEOUT_CYC without detection, the block SHALL set timeout=1, set last_delay=32'hFFFFFFFF, leave delay_sum and run_count unchanged, and go to DONE. Detection SHALL win if it occurs on the same cycle as the timeout.
REQ-012 Delta SHALL equal end_cnt - start_cnt modulo 2^32, so that a wrap of result between the two samples yields the correct small value.
REQ-013 RECORD (1 cycle): last_delay SHALL be set to delta, delay_sum SHALL be incremented by the zero-extended delta, and run_count SHALL be incremented. If the new run_count equals NUM_RUNS the FSM SHALL go to DONE, else to ARM.
REQ-014 DONE: ld=0 and done=1 for exactly one cycle, then go to IDLE. last_delay, delay_sum, run_count and timeout SHALL hold until the next accepted start or rst.
REQ-015 ld SHALL be 1 in ARM, LAUNCH, WAIT and RECORD, and 0 in IDLE and DONE.
REQ-016 pathInput SHALL change only at LAUNCH; it SHALL NOT return to 0 between runs.
REQ-017 Fixed measurement offset: with a zero-delay path and an ideal counter, delta SHALL be 3. A path that settles after D whole cycles SHALL give 3+D. No offset correction is applied in this block.
REQ-018 delay_sum SHALL NOT overflow: 255 x (2^32-1) < 2^40.

Reset
REQ-019 On rst=1 at a clk edge, the block SHALL force state=IDLE and ld=0, pathInput=0, busy=0, done=0, timeout=0, last_delay=0, delay_sum=0 and run_count=0. It SHALL also clear sync1, sync2, ref_level, start_cnt, end_cnt and the wait counter.
REQ-020 A reset asserted mid-batch, in any state, SHALL abort the batch with no done pulse. start SHALL be ignored in the same cycle as rst.

Verification
REQ-021 Zero-delay path (pathResult = ~pathInput combinationally), NUM_RUNS=1, start pulse -> done pulse once; last_delay=3, delay_sum=3, run_count=1, timeout=0.
REQ-022 Modelled path delay D=5 cycles, NUM_RUNS=8 -> last_delay=8, delay_sum=64, run_count=8. pathInput toggles 8 times, ending at 0.
REQ-023 Counter preset to 32'hFFFFFFFE at launch, D=0 -> last_delay=3 across the wrap.
REQ-024 pathResult stuck at 0, TIMEOUT_CYC=16 -> timeout=1 after 16 WAIT cycles, last_delay=32'hFFFFFFFF, run_count=0, done pulses; the next start clears timeout.
REQ-025 rst asserted during WAIT of run 3 of 8 -> next cycle all outputs are 0 and state is IDLE with no done pulse; a subsequent start runs a full 8-run batch.
REQ-026 start asserted while busy, both in ARM and in WAIT -> ignored: the batch result, run count and sum are identical to a run without the extra start.

Source files
------------

// File: rtl/delay_controller.sv
// delay_controller: measures launch-to-capture delay of an external path over NUM_RUNS runs using a free-running datapath counter
module delay_controller #(
    parameter int NUM_RUNS    = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] result,
    input  logic        pathResult,
    output logic        ld,
    output logic        pathInput,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] last_delay,
    output logic [39:0] delay_sum,
    output logic [7:0]  run_count
);
    typedef enum logic [2:0] {IDLE, ARM, LAUNCH, WAIT, RECORD, DONE} state_t;
    state_t      r_state, w_state;
    logic        r_sync1, r_sync2, r_ref, r_ld, r_pi, r_busy, r_done, r_timeout;
    logic [1:0]  r_arm_cnt;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_start_cnt, r_end_cnt, r_last, w_delta;
    logic [39:0] r_sum;
    logic [7:0]  r_run_count, w_runs;
    logic        w_hit, w_tmo;
    assign ld         = r_ld;
    assign pathInput  = r_pi;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign last_delay = r_last;
    assign delay_sum  = r_sum;
    assign run_count  = r_run_count;
    always_comb begin
        w_state = r_state;
        w_hit   = r_sync2 != r_ref;
        w_tmo   = r_wait_cnt == 16'(TIMEOUT_CYC - 1);
        w_delta = r_end_cnt - r_start_cnt;
        w_runs  = r_run_count + 8'd1;
        case (r_state)
            IDLE:    w_state = start ? ARM : IDLE;
            ARM:     w_state = (r_arm_cnt == 2'd3) ? LAUNCH : ARM;
            LAUNCH:  w_state = WAIT;
            WAIT:    w_state = w_hit ? RECORD : (w_tmo ? DONE : WAIT);
            RECORD:  w_state = (w_runs == 8'(NUM_RUNS)) ? DONE : ARM;
            DONE:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_ref       <= 1'b0;
            r_ld        <= 1'b0;
            r_pi        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_arm_cnt   <= 2'd0;
            r_wait_cnt  <= 16'd0;
            r_start_cnt <= 32'd0;
            r_end_cnt   <= 32'd0;
            r_last      <= 32'd0;
            r_sum       <= 40'd0;
            r_run_count <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_sync1    <= pathResult;
            r_sync2    <= r_sync1;
            r_ld       <= w_state inside {ARM, LAUNCH, WAIT, RECORD};
            r_busy     <= w_state != IDLE;
            r_done     <= w_state == DONE;
            r_arm_cnt  <= (r_state == ARM) ? r_arm_cnt + 2'd1 : 2'd0;
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 16'd1 : 16'd0;
            if (r_state == IDLE && start) begin
                r_sum       <= 40'd0;
                r_run_count <= 8'd0;
                r_timeout   <= 1'b0;
            end
            if (r_state == ARM && r_arm_cnt == 2'd3)
                r_ref <= r_sync2;
            if (r_state == LAUNCH) begin
                r_pi        <= ~r_pi;
                r_start_cnt <= result;
            end
            if (r_state == WAIT && w_hit)
                r_end_cnt <= result;
            // detection has priority over a coincident timeout
            if (r_state == WAIT && !w_hit && w_tmo) begin
                r_timeout <= 1'b1;
                r_last    <= 32'hFFFF_FFFF;
            end
            if (r_state == RECORD) begin
                r_last      <= w_delta;
                r_sum       <= r_sum + {8'd0, w_delta};
                r_run_count <= w_runs;
            end
        end
    end
endmodule

// File: tb/tb_delay_controller.sv
// tb_delay_controller: scoreboard bench with directed batches on an 8-run and a 1-run controller
module tb_delay_controller;
    typedef struct packed {
        logic [31:0] last;
        logic [39:0] sum;
        logic [7:0]  cnt;
        logic        tmo;
    } exp_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst = 1'b1, start8 = 1'b0, start1 = 1'b0, preset = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [4:0]  dly = 5'b11111;
    logic [31:0] cnt8 = 32'd0, cnt1 = 32'd0;
    logic        pr8, pr1, ld8, pi8, busy8, done8, tmo8, ld1, pi1, busy1, done1, tmo1;
    logic [31:0] last8, last1;
    logic [39:0] sum8, sum1;
    logic [7:0]  rc8, rc1;
    logic        pi_prev = 1'b0;
    int          tog = 0;
    int          n_checks = 0, n_fail = 0;
    exp_t        q8[$], q1[$];
    delay_controller #(.NUM_RUNS(8), .TIMEOUT_CYC(16)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .result(cnt8), .pathResult(pr8),
        .ld(ld8), .pathInput(pi8), .busy(busy8), .done(done8), .timeout(tmo8),
        .last_delay(last8), .delay_sum(sum8), .run_count(rc8));
    delay_controller #(.NUM_RUNS(1), .TIMEOUT_CYC(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .result(cnt1), .pathResult(pr1),
        .ld(ld1), .pathInput(pi1), .busy(busy1), .done(done1), .timeout(tmo1),
        .last_delay(last1), .delay_sum(sum1), .run_count(rc1));
    // datapath counters and path models: 0 = zero delay, 1 = 5-cycle delay, 2 = stuck at 0
    always @(posedge clk) begin
        cnt8    <= preset ? 32'hFFFF_FFFA : cnt8 + {31'd0, ld8};
        cnt1    <= cnt1 + {31'd0, ld1};
        dly     <= {dly[3:0], ~pi8};
        pi_prev <= pi8;
    end
    assign pr8 = (mode == 2'd0) ? ~pi8 : (mode == 2'd1) ? dly[4] : 1'b0;
    assign pr1 = ~pi1;
    always @(negedge clk) if (pi8 != pi_prev) tog++;
    function automatic exp_t mk(input logic [31:0] l, input logic [39:0] s, input logic [7:0] c, input logic t);
        return exp_t'{l, s, c, t};
    endfunction
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) check("done8_unexpected", 64'(done8), 64'd0);
            else begin
                e = q8.pop_front();
                check("dut8_last_delay", 64'(last8), 64'(e.last));
                check("dut8_delay_sum", 64'(sum8), 64'(e.sum));
                check("dut8_run_count", 64'(rc8), 64'(e.cnt));
                check("dut8_timeout", 64'(tmo8), 64'(e.tmo));
            end
        end
        if (done1) begin
            if (q1.size() == 0) check("done1_unexpected", 64'(done1), 64'd0);
            else begin
                e = q1.pop_front();
                check("dut1_last_delay", 64'(last1), 64'(e.last));
                check("dut1_delay_sum", 64'(sum1), 64'(e.sum));
                check("dut1_run_count", 64'(rc1), 64'(e.cnt));
                check("dut1_timeout", 64'(tmo1), 64'(e.tmo));
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulse8();
        start8 = 1'b1;
        tick(1);
        start8 = 1'b0;
    endtask
    task automatic drain(input int bound);
        int i = 0;
        while ((q8.size() + q1.size()) != 0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        check("drain_scoreboard", 64'(q8.size() + q1.size()), 64'd0);
    endtask
    task automatic wait_tog(input int target, input int bound);
        int i = 0;
        while (tog < target && i < bound) begin
            @(negedge clk);
            i++;
        end
        check("wait_toggle", 64'(tog >= target), 64'd1);
    endtask
    task automatic check_cleared(input string tag);
        check({tag, "_ld"}, 64'(ld8), 64'd0);
        check({tag, "_pathInput"}, 64'(pi8), 64'd0);
        check({tag, "_busy"}, 64'(busy8), 64'd0);
        check({tag, "_done"}, 64'(done8), 64'd0);
        check({tag, "_timeout"}, 64'(tmo8), 64'd0);
        check({tag, "_last_delay"}, 64'(last8), 64'd0);
        check({tag, "_delay_sum"}, 64'(sum8), 64'd0);
        check({tag, "_run_count"}, 64'(rc8), 64'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int t0, lat;
        tick(3);
        check_cleared("reset");
        rst = 1'b0;
        tick(2);
        // single-run controller, zero-delay path
        q1.push_back(mk(32'd3, 40'd3, 8'd1, 1'b0));
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        // zero-delay batch with counter wrapping across the first launch
        preset = 1'b1;
        tick(1);
        preset = 1'b0;
        q8.push_back(mk(32'd3, 40'd24, 8'd8, 1'b0));
        pulse8();
        drain(300);
        // 5-cycle path, 8 runs
        mode = 2'd1;
        tick(8);
        t0 = tog;
        q8.push_back(mk(32'd8, 40'd64, 8'd8, 1'b0));
        pulse8();
        drain(400);
        check("d5_toggles", 64'(tog - t0), 64'd8);
        check("d5_final_pathInput", 64'(pi8), 64'd0);
        tick(5);
        check("hold_run_count", 64'(rc8), 64'd8);
        check("hold_delay_sum", 64'(sum8), 64'd64);
        check("hold_busy", 64'(busy8), 64'd0);
        // extra starts during ARM and WAIT are ignored
        t0 = tog;
        q8.push_back(mk(32'd8, 40'd64, 8'd8, 1'b0));
        pulse8();
        tick(2);
        pulse8();
        wait_tog(t0 + 1, 100);
        tick(2);
        pulse8();
        drain(400);
        // stuck path times out after 16 WAIT cycles
        mode = 2'd2;
        tick(8);
        q8.push_back(mk(32'hFFFF_FFFF, 40'd0, 8'd0, 1'b1));
        start8 = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                lat = n;
                break;
            end
        end
        check("timeout_latency", 64'(lat), 64'd22);
        tick(3);
        check("timeout_sticky", 64'(tmo8), 64'd1);
        check("timeout_last_delay", 64'(last8), 64'hFFFF_FFFF);
        // next start clears timeout
        mode = 2'd0;
        tick(8);
        q8.push_back(mk(32'd3, 40'd24, 8'd8, 1'b0));
        pulse8();
        check("start_clears_timeout", 64'(tmo8), 64'd0);
        drain(300);
        // reset during WAIT of run 3 aborts without done; start alongside rst is ignored
        mode = 2'd1;
        tick(8);
        t0 = tog;
        pulse8();
        wait_tog(t0 + 3, 200);
        check("pre_reset_run_count", 64'(rc8), 64'd2);
        check("pre_reset_delay_sum", 64'(sum8), 64'd16);
        rst = 1'b1;
        start8 = 1'b1;
        tick(1);
        check_cleared("abort");
        rst = 1'b0;
        start8 = 1'b0;
        tick(1);
        check("start_with_rst_ignored", 64'(busy8), 64'd0);
        tick(10);
        t0 = tog;
        q8.push_back(mk(32'd8, 40'd64, 8'd8, 1'b0));
        pulse8();
        drain(400);
        check("post_reset_toggles", 64'(tog - t0), 64'd8);
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
